pass_verifier_param: RTL and testbench

//  Parametrised successor to the switch-based password checker. The user enters a code of

---
 rtl/pass_verifier_param.sv | 110 +++++++++++
 tb/tb_pass_verifier_param.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/pass_verifier_param.sv
// pass_verifier_param: one-hot switch code lock with loadable code, inter-digit timeout, retry limit and timed lockout
module pass_verifier_param #(
  parameter int SW_W = 10,
  parameter int CODE_LEN = 4,
  parameter logic [CODE_LEN*$clog2(SW_W)-1:0] DEFAULT_CODE = {4'd2, 4'd0, 4'd1, 4'd4},
  parameter int MAX_TRIES = 3,
  parameter int TIMEOUT_CYC = 1000000,
  parameter int LOCK_CYC = 5000000
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [SW_W-1:0]                     Sw,
  input  logic [CODE_LEN*$clog2(SW_W)-1:0]    code_in,
  input  logic                                code_load,
  input  logic                                relock,
  output logic [3:0]                          status_out,
  output logic                                unlocked,
  output logic                                locked_out,
  output logic [$clog2(MAX_TRIES+1)-1:0]      tries_left
);
  localparam int IDX_W = $clog2(SW_W);
  localparam int CW = CODE_LEN * IDX_W;
  localparam int CNT_W = $clog2(CODE_LEN + 1);
  localparam int TRY_W = $clog2(MAX_TRIES + 1);
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam int LCK_W = $clog2(LOCK_CYC + 1);
  localparam logic [2:0] IDLE = 3'd0, ENTRY = 3'd1, DONE = 3'd2, ERROR = 3'd3, LOCKED = 3'd4;
  logic [2:0] state;
  logic [SW_W-1:0] sw_prev;
  logic [CW-1:0] code;
  logic [CNT_W-1:0] cnt;
  logic [TRY_W-1:0] tries, tries_dec;
  logic [TMR_W-1:0] tmr;
  logic [LCK_W-1:0] ltmr;
  logic [IDX_W-1:0] sw_idx, exp_digit;
  logic miss_flag, ev, one_hot, miss, bad, last;
  always_comb begin
    sw_idx = '0;
    for (int i = 0; i < SW_W; i++) sw_idx = Sw[i] ? IDX_W'(i) : sw_idx;
  end
  always_comb begin
    exp_digit = '0;
    for (int d = 0; d < CODE_LEN; d++)
      exp_digit = (cnt == CNT_W'(d)) ? code[(CODE_LEN-1-d)*IDX_W +: IDX_W] : exp_digit;
  end
  assign ev = sw_prev == '0 && Sw != '0;
  assign one_hot = (Sw & (Sw - SW_W'(1))) == '0;
  // a non-one-hot press is a wrong digit but still consumes a position
  assign miss = !one_hot || sw_idx != exp_digit;
  assign bad = miss_flag || miss;
  assign last = cnt == CNT_W'(CODE_LEN - 1);
  assign tries_dec = tries == '0 ? '0 : tries - TRY_W'(1);
  assign status_out = {1'b0, state};
  assign unlocked = state == DONE;
  assign locked_out = state == LOCKED;
  assign tries_left = tries;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      sw_prev <= '0;
      code <= DEFAULT_CODE;
      cnt <= '0;
      miss_flag <= 1'b0;
      tries <= TRY_W'(MAX_TRIES);
      tmr <= '0;
      ltmr <= '0;
    end else begin
      sw_prev <= Sw;
      case (state)
        IDLE, ENTRY: begin
          if (state == IDLE && code_load) code <= code_in;
          if (ev) begin
            tmr <= '0;
            if (last) begin
              state <= bad ? ERROR : DONE;
              tries <= bad ? tries_dec : TRY_W'(MAX_TRIES);
              cnt <= '0;
              miss_flag <= 1'b0;
            end else begin
              state <= ENTRY;
              cnt <= cnt + CNT_W'(1);
              miss_flag <= bad;
            end
          end else if (state == ENTRY) begin
            if (tmr == TMR_W'(TIMEOUT_CYC - 1)) begin
              state <= ERROR;
              tries <= tries_dec;
              cnt <= '0;
              miss_flag <= 1'b0;
              tmr <= '0;
            end else tmr <= tmr + TMR_W'(1);
          end
        end
        DONE: begin
          if (code_load) code <= code_in;
          if (relock) state <= IDLE;
        end
        ERROR: if (Sw == '0) state <= tries == '0 ? LOCKED : IDLE;
        LOCKED: begin
          if (ltmr == LCK_W'(LOCK_CYC - 1)) begin
            state <= IDLE;
            tries <= TRY_W'(MAX_TRIES);
            ltmr <= '0;
          end else ltmr <= ltmr + LCK_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pass_verifier_param.sv
// tb_pass_verifier_param: directed scenarios for the code lock with short timeout/lockout
module tb_pass_verifier_param;
  logic clk = 1'b0;
  logic rst;
  logic [9:0] Sw;
  logic [15:0] code_in;
  logic code_load, relock;
  logic [3:0] status_out;
  logic unlocked, locked_out;
  logic [1:0] tries_left;
  int checks = 0;
  int failures = 0;

  pass_verifier_param #(.TIMEOUT_CYC(20), .LOCK_CYC(50)) dut (
    .clk(clk), .rst(rst), .Sw(Sw), .code_in(code_in), .code_load(code_load),
    .relock(relock), .status_out(status_out), .unlocked(unlocked),
    .locked_out(locked_out), .tries_left(tries_left)
  );

  always #5 clk = ~clk;

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic press_raw(input logic [9:0] s, output logic [3:0] st);
    Sw = s;
    cyc();
    st = status_out;
    Sw = '0;
    cyc();
  endtask

  task automatic press(input int v, output logic [3:0] st);
    press_raw(10'(1 << v), st);
  endtask

  task automatic do_reset;
    rst = 1'b0;
    Sw = '0;
    code_in = '0;
    code_load = 1'b0;
    relock = 1'b0;
    cyc();
    cyc();
    rst = 1'b1;
  endtask

  task automatic test_reset;
    do_reset();
    checks++; if (status_out !== 4'd0) begin failures++; $display("FAIL reset_status got=%0d exp=0", status_out); end
    checks++; if (unlocked !== 1'b0) begin failures++; $display("FAIL reset_unlocked got=%b exp=0", unlocked); end
    checks++; if (locked_out !== 1'b0) begin failures++; $display("FAIL reset_locked got=%b exp=0", locked_out); end
    checks++; if (tries_left !== 2'd3) begin failures++; $display("FAIL reset_tries got=%0d exp=3", tries_left); end
  endtask

  task automatic test_unlock;
    int seq[4] = '{2, 0, 1, 4};
    logic [3:0] exp_st[4] = '{4'd1, 4'd1, 4'd1, 4'd2};
    logic [3:0] st;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      press(seq[i], st);
      checks++; if (st !== exp_st[i]) begin failures++; $display("FAIL unlock_press%0d got=%0d exp=%0d", i, st, exp_st[i]); end
    end
    checks++; if (unlocked !== 1'b1) begin failures++; $display("FAIL unlock_flag got=%b exp=1", unlocked); end
    checks++; if (tries_left !== 2'd3) begin failures++; $display("FAIL unlock_tries got=%0d exp=3", tries_left); end
  endtask

  task automatic test_wrong_digit;
    int seq[4] = '{2, 0, 7, 4};
    logic [3:0] exp_st[4] = '{4'd1, 4'd1, 4'd1, 4'd3};
    logic [3:0] st;
    relock = 1'b1;
    cyc();
    relock = 1'b0;
    checks++; if (status_out !== 4'd0) begin failures++; $display("FAIL relock_status got=%0d exp=0", status_out); end
    for (int i = 0; i < 4; i++) begin
      press(seq[i], st);
      checks++; if (st !== exp_st[i]) begin failures++; $display("FAIL wrong_press%0d got=%0d exp=%0d", i, st, exp_st[i]); end
    end
    checks++; if (tries_left !== 2'd2) begin failures++; $display("FAIL wrong_tries got=%0d exp=2", tries_left); end
    checks++; if (status_out !== 4'd0) begin failures++; $display("FAIL wrong_release got=%0d exp=0", status_out); end
  endtask

  task automatic test_multibit;
    logic [3:0] st;
    do_reset();
    press_raw(10'b0000000101, st);
    checks++; if (st !== 4'd1) begin failures++; $display("FAIL multi_first got=%0d exp=1", st); end
    press(0, st);
    press(1, st);
    press(4, st);
    checks++; if (st !== 4'd3) begin failures++; $display("FAIL multi_verdict got=%0d exp=3", st); end
    checks++; if (tries_left !== 2'd2) begin failures++; $display("FAIL multi_tries got=%0d exp=2", tries_left); end
  endtask

  task automatic test_lockout;
    logic [3:0] st;
    int good[4] = '{2, 0, 1, 4};
    do_reset();
    for (int a = 0; a < 3; a++) begin
      for (int i = 0; i < 4; i++) press(1, st);
      checks++; if (st !== 4'd3) begin failures++; $display("FAIL lock_attempt%0d got=%0d exp=3", a, st); end
      checks++; if (tries_left !== 2'(2 - a)) begin failures++; $display("FAIL lock_tries%0d got=%0d exp=%0d", a, tries_left, 2 - a); end
    end
    checks++; if (status_out !== 4'd4) begin failures++; $display("FAIL lock_status got=%0d exp=4", status_out); end
    checks++; if (locked_out !== 1'b1) begin failures++; $display("FAIL lock_flag got=%b exp=1", locked_out); end
    for (int i = 0; i < 4; i++) begin
      press(good[i], st);
      checks++; if (st !== 4'd4) begin failures++; $display("FAIL lock_ignore%0d got=%0d exp=4", i, st); end
    end
    repeat (41) cyc();
    checks++; if (status_out !== 4'd4) begin failures++; $display("FAIL lock_cyc49 got=%0d exp=4", status_out); end
    cyc();
    checks++; if (status_out !== 4'd0) begin failures++; $display("FAIL lock_expire got=%0d exp=0", status_out); end
    checks++; if (tries_left !== 2'd3) begin failures++; $display("FAIL lock_tries_reload got=%0d exp=3", tries_left); end
    checks++; if (locked_out !== 1'b0) begin failures++; $display("FAIL lock_flag_clear got=%b exp=0", locked_out); end
  endtask

  task automatic test_timeout;
    logic [3:0] st;
    do_reset();
    press(2, st);
    repeat (18) cyc();
    checks++; if (status_out !== 4'd1) begin failures++; $display("FAIL tmo_cyc19 got=%0d exp=1", status_out); end
    cyc();
    checks++; if (status_out !== 4'd3) begin failures++; $display("FAIL tmo_expire got=%0d exp=3", status_out); end
    checks++; if (tries_left !== 2'd2) begin failures++; $display("FAIL tmo_tries got=%0d exp=2", tries_left); end
    cyc();
    checks++; if (status_out !== 4'd0) begin failures++; $display("FAIL tmo_idle got=%0d exp=0", status_out); end
    press(2, st);
    repeat (18) cyc();
    press(0, st);
    checks++; if (st !== 4'd1) begin failures++; $display("FAIL tmo_edge_press got=%0d exp=1", st); end
    press(1, st);
    press(4, st);
    checks++; if (st !== 4'd2) begin failures++; $display("FAIL tmo_edge_unlock got=%0d exp=2", st); end
    checks++; if (tries_left !== 2'd3) begin failures++; $display("FAIL tmo_edge_tries got=%0d exp=3", tries_left); end
  endtask

  task automatic test_code_load_reset;
    logic [3:0] st;
    int old_c[4] = '{2, 0, 1, 4};
    int new_c[4] = '{9, 8, 7, 6};
    do_reset();
    for (int i = 0; i < 4; i++) press(old_c[i], st);
    checks++; if (st !== 4'd2) begin failures++; $display("FAIL load_pre_done got=%0d exp=2", st); end
    code_in = 16'h9876;
    code_load = 1'b1;
    relock = 1'b1;
    cyc();
    code_load = 1'b0;
    relock = 1'b0;
    checks++; if (status_out !== 4'd0) begin failures++; $display("FAIL load_relock got=%0d exp=0", status_out); end
    for (int i = 0; i < 4; i++) press(old_c[i], st);
    checks++; if (st !== 4'd3) begin failures++; $display("FAIL load_old_code got=%0d exp=3", st); end
    checks++; if (tries_left !== 2'd2) begin failures++; $display("FAIL load_old_tries got=%0d exp=2", tries_left); end
    for (int i = 0; i < 4; i++) press(new_c[i], st);
    checks++; if (st !== 4'd2) begin failures++; $display("FAIL load_new_code got=%0d exp=2", st); end
    checks++; if (tries_left !== 2'd3) begin failures++; $display("FAIL load_new_tries got=%0d exp=3", tries_left); end
    relock = 1'b1;
    cyc();
    relock = 1'b0;
    press(9, st);
    press(8, st);
    checks++; if (st !== 4'd1) begin failures++; $display("FAIL rst_mid_entry got=%0d exp=1", st); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (status_out !== 4'd0) begin failures++; $display("FAIL rst_async got=%0d exp=0", status_out); end
    cyc();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) press(old_c[i], st);
    checks++; if (st !== 4'd2) begin failures++; $display("FAIL rst_code_revert got=%0d exp=2", st); end
    checks++; if (unlocked !== 1'b1) begin failures++; $display("FAIL rst_unlocked got=%b exp=1", unlocked); end
  endtask

  initial begin
    test_reset();
    test_unlock();
    test_wrong_digit();
    test_multibit();
    test_lockout();
    test_timeout();
    test_code_load_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
